// File: rtl/alu_seq16.sv
// 16-bit ADD/SUB/INC/DEC sequencer built on an external 8-bit ALU.
// Each operation runs low byte, then high byte, plus an optional carry/borrow fix-up.
module alu_seq16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_flags,
  output logic        alu_enable,
  output logic [1:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_status
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LO   = 3'd1;
  localparam logic [2:0] ST_HI   = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]  state_r;
  logic [2:0]  state_next_s;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic        sub_r;
  logic [7:0]  res_lo_r;
  logic [7:0]  res_hi_r;
  logic        c_lo_r;
  logic        c_hi_r;
  logic        h_r;
  logic [15:0] rsp_result_r;
  logic [7:0]  rsp_flags_r;
  logic        c_fix_s;
  logic        unused_s;

  // Only carry (bit 0) and half-carry (bit 4) of the ALU status are consumed.
  assign unused_s = ^{alu_status[7:5], alu_status[3:1]};

  // Flag byte: S Z 0 H 0 P/V N C
  function automatic logic [7:0] make_flags(
    input logic [15:0] res,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        sub,
    input logic        h,
    input logic        c
  );
    logic pv;
    if (sub) begin
      pv = (a[15] != b[15]) && (res[15] != a[15]);
    end else begin
      pv = (a[15] == b[15]) && (res[15] != a[15]);
    end
    return {res[15], (res == 16'h0000), 1'b0, h, 1'b0, pv, sub, c};
  endfunction

  // The fix-up carry comes from the pre-adjust high byte, never from the ALU.
  assign c_fix_s = sub_r ? (res_hi_r == 8'h00) : (res_hi_r == 8'hFF);

  assign req_ready  = (state_r == ST_IDLE);
  assign rsp_valid  = (state_r == ST_DONE);
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_next_s = ST_LO;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LO: state_next_s = ST_HI;
      ST_HI: begin
        if (c_lo_r) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_FIX: state_next_s = ST_DONE;
      ST_DONE: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // ALU drive decoded from the current state.
  always_comb begin
    alu_enable = 1'b0;
    alu_opcode = OP_ADD;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    case (state_r)
      ST_LO: begin
        alu_enable = 1'b1;
        alu_opcode = sub_r ? OP_SUB : OP_ADD;
        alu_a      = a_r[7:0];
        alu_b      = b_r[7:0];
      end
      ST_HI: begin
        alu_enable = 1'b1;
        alu_opcode = sub_r ? OP_SUB : OP_ADD;
        alu_a      = a_r[15:8];
        alu_b      = b_r[15:8];
      end
      ST_FIX: begin
        alu_enable = 1'b1;
        alu_opcode = sub_r ? OP_DEC : OP_INC;
        alu_a      = res_hi_r;
        alu_b      = 8'h00;
      end
      default: begin
        alu_enable = 1'b0;
        alu_opcode = OP_ADD;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, per-byte results and the registered response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r          <= 16'h0000;
      b_r          <= 16'h0000;
      sub_r        <= 1'b0;
      res_lo_r     <= 8'h00;
      res_hi_r     <= 8'h00;
      c_lo_r       <= 1'b0;
      c_hi_r       <= 1'b0;
      h_r          <= 1'b0;
      rsp_result_r <= 16'h0000;
      rsp_flags_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            a_r <= req_a;
            case (req_op)
              OP_ADD: begin
                b_r   <= req_b;
                sub_r <= 1'b0;
              end
              OP_SUB: begin
                b_r   <= req_b;
                sub_r <= 1'b1;
              end
              OP_INC: begin
                b_r   <= 16'h0001;
                sub_r <= 1'b0;
              end
              OP_DEC: begin
                b_r   <= 16'h0001;
                sub_r <= 1'b1;
              end
              default: begin
                b_r   <= req_b;
                sub_r <= 1'b0;
              end
            endcase
          end
        end
        ST_LO: begin
          res_lo_r <= alu_out;
          c_lo_r   <= alu_status[0];
        end
        ST_HI: begin
          res_hi_r <= alu_out;
          c_hi_r   <= alu_status[0];
          h_r      <= alu_status[4];
          // No low-byte carry: the response is final on this edge.
          if (!c_lo_r) begin
            rsp_result_r <= {alu_out, res_lo_r};
            rsp_flags_r  <= make_flags({alu_out, res_lo_r}, a_r, b_r, sub_r,
                                       alu_status[4], alu_status[0]);
          end
        end
        ST_FIX: begin
          res_hi_r     <= alu_out;
          rsp_result_r <= {alu_out, res_lo_r};
          rsp_flags_r  <= make_flags({alu_out, res_lo_r}, a_r, b_r, sub_r,
                                     h_r, c_hi_r | c_fix_s);
        end
        default: begin
          res_hi_r <= res_hi_r;
        end
      endcase
    end
  end

endmodule
